// File: rtl/array_result_collector_if.sv
// Stream bus for the result collector: serialized input strobe plus the
// ready/valid packet output.
interface array_result_collector_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;

  // master is the collector's own view; slave is the producer/consumer side
  modport master (
    input  in_data, in_valid, m_ready,
    output m_data, m_valid, m_last
  );

  modport slave (
    output in_data, in_valid, m_ready,
    input  m_data, m_valid, m_last
  );
endinterface

// File: rtl/array_result_collector.sv
// Captures array stream results into a circular FIFO, tags every FRAME-th word as
// packet end and re-emits them on a ready/valid port with drop detection.
module array_result_collector #(
  parameter int W     = 32,
  parameter int DEPTH = 32,
  parameter int FRAME = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  array_result_collector_if.master bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clear_ovf,
  output logic [15:0]            frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(FRAME);

  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   level_next;
  logic [IW-1:0] in_idx;
  logic          pop;
  logic          push;
  logic          drop;
  logic          in_last;
  logic [W-1:0]  m_data_q;
  logic          m_last_q;
  logic          m_valid_q;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_valid = m_valid_q;

  always_comb begin
    pop        = m_valid_q && bus.m_ready;
    push       = bus.in_valid && (!full || pop);
    drop       = bus.in_valid && !push;
    in_last    = (in_idx == IW'(FRAME - 1));
    rd_next    = rd_ptr + AW'(pop);
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {in_last, bus.in_data};
    end
  end

  // The output stage is reloaded with the next head every cycle; when the FIFO is
  // draining to empty while a word arrives, that word bypasses storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      in_idx      <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      level  <= level_next;
      if (bus.in_valid) begin
        in_idx <= in_last ? '0 : in_idx + 1'b1;
      end
      m_valid_q <= (level_next != '0);
      if (level_next != '0) begin
        if (push && (wr_ptr == rd_next)) begin
          {m_last_q, m_data_q} <= {in_last, bus.in_data};
        end else begin
          {m_last_q, m_data_q} <= mem[rd_next];
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
      if (pop && m_last_q) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_array_result_collector.sv
// Directed self-checking bench for array_result_collector.
module tb_array_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_ovf;
  logic [5:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] frame_count;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] got_q[$];

  array_result_collector_if #(.W(32)) bus ();

  array_result_collector #(.W(32), .DEPTH(32), .FRAME(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got timeout exp finish");
    $fatal(1, "[TB] watchdog");
  end

  // Records a pop if one will happen at the coming edge, then advances one cycle.
  task automatic tick();
    if (bus.m_valid && bus.m_ready) got_q.push_back({bus.m_last, bus.m_data});
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bus.m_ready  = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < max_cycles && bus.m_valid; i++) tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.m_ready  = 1'b0;
    clear_ovf    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 6'd0) begin errors++; $display("[TB] FAIL reset_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b exp 0", full); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %b exp 0", bus.m_valid); end
    checks++; if (bus.m_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_m_data got %h exp 0", bus.m_data); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last got %b exp 0", bus.m_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_count got %0d exp 0", frame_count); end
  endtask

  task automatic test_single_packet();
    logic [32:0] exp;
    do_reset();
    bus.m_ready = 1'b1;
    push_word(32'h100);
    checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h100) begin
      errors++; $display("[TB] FAIL latency got valid=%b data=%h exp valid=1 data=100", bus.m_valid, bus.m_data);
    end
    for (int i = 1; i < 16; i++) push_word(32'h100 + i);
    drain(40);
    checks++; if (got_q.size() != 16) begin errors++; $display("[TB] FAIL pkt1_count got %0d exp 16", got_q.size()); end
    else for (int i = 0; i < 16; i++) begin
      exp = {(i == 15), 32'h100 + i};
      checks++; if (got_q[i] !== exp) begin errors++; $display("[TB] FAIL pkt1_word%0d got %h exp %h", i, got_q[i], exp); end
    end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL pkt1_frame_count got %0d exp 1", frame_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pkt1_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [32:0] exp;
    do_reset();
    for (int i = 0; i < 32; i++) push_word(32'h200 + i);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %b exp 1", full); end
    checks++; if (level !== 6'd32) begin errors++; $display("[TB] FAIL ovf_level_full got %0d exp 32", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_not_yet got %b exp 0", overflow); end
    push_word(32'h220);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_first_drop got %b exp 1", overflow); end
    push_word(32'h221);
    push_word(32'h222);
    checks++; if (level !== 6'd32) begin errors++; $display("[TB] FAIL ovf_level_kept got %0d exp 32", level); end
    drain(60);
    checks++; if (got_q.size() != 32) begin errors++; $display("[TB] FAIL ovf_count got %0d exp 32", got_q.size()); end
    else for (int i = 0; i < 32; i++) begin
      exp = {(i % 16 == 15), 32'h200 + i};
      checks++; if (got_q[i] !== exp) begin errors++; $display("[TB] FAIL ovf_word%0d got %h exp %h", i, got_q[i], exp); end
    end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("[TB] FAIL ovf_frame_count got %0d exp 2", frame_count); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared got %b exp 0", overflow); end
    // third packet already lost its first three words, so only 13 remain
    got_q.delete();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 13; i++) push_word(32'h223 + i);
    drain(40);
    checks++; if (got_q.size() != 13) begin errors++; $display("[TB] FAIL short_count got %0d exp 13", got_q.size()); end
    else for (int i = 0; i < 13; i++) begin
      exp = {(i == 12), 32'h223 + i};
      checks++; if (got_q[i] !== exp) begin errors++; $display("[TB] FAIL short_word%0d got %h exp %h", i, got_q[i], exp); end
    end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("[TB] FAIL short_frame_count got %0d exp 3", frame_count); end
  endtask

  task automatic test_full_push_pop();
    logic [32:0] exp;
    do_reset();
    for (int i = 0; i < 32; i++) push_word(32'h300 + i);
    bus.m_ready = 1'b1;
    push_word(32'h320);
    bus.m_ready = 1'b0;
    checks++; if (level !== 6'd32) begin errors++; $display("[TB] FAIL fpp_level got %0d exp 32", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp_overflow got %b exp 0", overflow); end
    checks++; if (bus.m_data !== 32'h301) begin errors++; $display("[TB] FAIL fpp_head got %h exp 301", bus.m_data); end
    drain(60);
    checks++; if (got_q.size() != 33) begin errors++; $display("[TB] FAIL fpp_count got %0d exp 33", got_q.size()); end
    else for (int i = 0; i < 33; i++) begin
      exp = {(i % 16 == 15), 32'h300 + i};
      checks++; if (got_q[i] !== exp) begin errors++; $display("[TB] FAIL fpp_word%0d got %h exp %h", i, got_q[i], exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    logic [31:0] held;
    logic        hold_valid;
    int          sent;
    do_reset();
    sent       = 0;
    hold_valid = 1'b0;
    held       = '0;
    for (int cyc = 0; cyc < 300 && got_q.size() < 48; cyc++) begin
      bus.in_valid = (sent < 48);
      bus.in_data  = 32'h400 + sent;
      bus.m_ready  = (cyc % 2 == 0);
      if (hold_valid) begin
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin
          errors++; $display("[TB] FAIL b2b_stall_hold got valid=%b data=%h exp valid=1 data=%h", bus.m_valid, bus.m_data, held);
        end
      end
      hold_valid = bus.m_valid && !bus.m_ready;
      held       = bus.m_data;
      if (bus.in_valid) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.m_ready  = 1'b0;
    checks++; if (got_q.size() != 48) begin errors++; $display("[TB] FAIL b2b_count got %0d exp 48", got_q.size()); end
    else for (int i = 0; i < 48; i++) begin
      exp = {(i % 16 == 15), 32'h400 + i};
      checks++; if (got_q[i] !== exp) begin errors++; $display("[TB] FAIL b2b_word%0d got %h exp %h", i, got_q[i], exp); end
    end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("[TB] FAIL b2b_frame_count got %0d exp 3", frame_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_clear_ovf();
    do_reset();
    for (int i = 0; i < 32; i++) push_word(32'h500 + i);
    clear_ovf = 1'b1;
    push_word(32'h5FF);
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_set_wins got %b exp 1", overflow); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_alone got %b exp 0", overflow); end
    checks++; if (level !== 6'd32) begin errors++; $display("[TB] FAIL clr_level got %0d exp 32", level); end
  endtask

  task automatic test_reset_mid_packet();
    logic [32:0] exp;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'h580 + i);
    drain(40);
    for (int i = 0; i < 23; i++) push_word(32'h5A0 + i);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    bus.m_ready = 1'b0;
    checks++; if (level !== 6'd10) begin errors++; $display("[TB] FAIL mid_level_before got %0d exp 10", level); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_fc_before got %0d exp 1", frame_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (level !== 6'd0) begin errors++; $display("[TB] FAIL mid_level_after got %0d exp 0", level); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_m_valid got %b exp 0", bus.m_valid); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_fc_after got %0d exp 0", frame_count); end
    got_q.delete();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'h600 + i);
    drain(40);
    checks++; if (got_q.size() != 16) begin errors++; $display("[TB] FAIL mid_count got %0d exp 16", got_q.size()); end
    else for (int i = 0; i < 16; i++) begin
      exp = {(i == 15), 32'h600 + i};
      checks++; if (got_q[i] !== exp) begin errors++; $display("[TB] FAIL mid_word%0d got %h exp %h", i, got_q[i], exp); end
    end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_fc_final got %0d exp 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear_ovf();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
